// File: rtl/vco_nco_qlut_pkg.sv
// Shared widths, amplitude and BTLE constants for the NCO.
// Also holds the quarter-wave sine generator used to fill the ROM.
package vco_nco_qlut_pkg;

  localparam int VCO_BIT_WIDTH_D  = 16;
  localparam int PHASE_WIDTH_D    = 16;
  localparam int GAIN_SHIFT_D     = 0;
  localparam int LUT_ADDR_WIDTH_D = 10;
  localparam int IQ_BIT_WIDTH_D   = 8;
  localparam int SAMPLES_PER_SYM  = 8;

  function automatic int amp_of(int iqw);
    return (1 << (iqw - 1)) - 1;
  endfunction

  // Mod index 0.5: a quarter turn per symbol.
  function automatic longint btle_inc(int pw, int sps);
    return (longint'(1) << pw) / 4 / longint'(sps);
  endfunction

  localparam longint BTLE_INC =
    btle_inc(PHASE_WIDTH_D, SAMPLES_PER_SYM);

  localparam longint PI_Q30 = 64'sd3373259426;

  // round(amp*sin(pi/2*i/n)) via a Q30 Taylor series,
  // evaluated only at elaboration time.
  function automatic int qsin(int i, int n, int amp);
    longint x, x2, term, sum;
    if (i <= 0) return 0;
    if (i >= n) return amp;
    x    = (PI_Q30 * longint'(i)) / longint'(2 * n);
    x2   = (x * x) >>> 30;
    term = x;
    sum  = x;
    for (int k = 1; k < 8; k++) begin
      term = -((term * x2) >>> 30)
             / longint'(2 * k * (2 * k + 1));
      sum  = sum + term;
    end
    return int'((sum * longint'(amp)
                 + (longint'(1) << 29)) >>> 30);
  endfunction

endpackage

// File: rtl/vco_nco_qlut_qrom.sv
// vco_sin_qrom: dual-read constant quarter-wave sine ROM.
// Ports: clk, rst_n, addr_a/addr_b in, mag_a/mag_b registered out.
module vco_sin_qrom
  import vco_nco_qlut_pkg::*;
#(
  parameter int LUT_ADDR_WIDTH = LUT_ADDR_WIDTH_D,
  parameter int IQ_BIT_WIDTH   = IQ_BIT_WIDTH_D
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [LUT_ADDR_WIDTH-2:0] addr_a,
  input  logic [LUT_ADDR_WIDTH-2:0] addr_b,
  output logic [IQ_BIT_WIDTH-2:0]   mag_a,
  output logic [IQ_BIT_WIDTH-2:0]   mag_b
);

  localparam int N   = 1 << (LUT_ADDR_WIDTH - 2);
  localparam int AMP = amp_of(IQ_BIT_WIDTH);
  localparam int MW  = IQ_BIT_WIDTH - 1;

  logic [MW-1:0] rom [0:N];

  for (genvar g = 0; g <= N; g++) begin : g_rom
    localparam int V = qsin(g, N, AMP);
    assign rom[g] = MW'(V);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_a <= '0;
      mag_b <= '0;
    end else begin
      mag_a <= rom[addr_a];
      mag_b <= rom[addr_b];
    end
  end

endmodule

// File: rtl/vco_nco_qlut.sv
// Frequency word to cos/sin NCO, 3-stage pipeline, quarter ROM.
// In: voltage_signal(+valid/last), phase_clear/offset. Out: cos/sin.
module vco_nco_qlut
  import vco_nco_qlut_pkg::*;
#(
  parameter int VCO_BIT_WIDTH  = VCO_BIT_WIDTH_D,
  parameter int PHASE_WIDTH    = PHASE_WIDTH_D,
  parameter int GAIN_SHIFT     = GAIN_SHIFT_D,
  parameter int LUT_ADDR_WIDTH = LUT_ADDR_WIDTH_D,
  parameter int IQ_BIT_WIDTH   = IQ_BIT_WIDTH_D
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [VCO_BIT_WIDTH-1:0] voltage_signal,
  input  logic                     voltage_signal_valid,
  input  logic                     voltage_signal_valid_last,
  input  logic                     phase_clear,
  input  logic [PHASE_WIDTH-1:0]   phase_offset,
  output logic [IQ_BIT_WIDTH-1:0]  cos_out,
  output logic [IQ_BIT_WIDTH-1:0]  sin_out,
  output logic                     sin_cos_out_valid,
  output logic                     sin_cos_out_valid_last
);

  localparam int LW = LUT_ADDR_WIDTH;
  localparam int AW = LW - 1;
  localparam int KW = LW - 2;
  localparam int MW = IQ_BIT_WIDTH - 1;

  localparam logic [LW-1:0] N_L = LW'(1 << KW);
  localparam logic [AW-1:0] N_A = AW'(1 << KW);

  logic [PHASE_WIDTH-1:0] inc;
  logic [PHASE_WIDTH-1:0] base;
  logic [PHASE_WIDTH-1:0] phase_nxt;
  logic [PHASE_WIDTH-1:0] phase_acc;

  logic [LW-1:0] a1;
  logic [LW-1:0] b1;
  logic          v1, l1;

  logic [AW-1:0] sin_addr, cos_addr;
  logic [MW-1:0] sin_mag, cos_mag;
  logic          sin_neg2, cos_neg2;
  logic          v2, l2;

  assign inc = voltage_signal_valid
    ? (PHASE_WIDTH'($signed(voltage_signal))
       << GAIN_SHIFT)
    : '0;

  assign base      = phase_clear ? phase_offset
                                 : phase_acc;
  assign phase_nxt = base + inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_acc <= '0;
      a1        <= '0;
      v1        <= 1'b0;
      l1        <= 1'b0;
    end else begin
      phase_acc <= phase_nxt;
      a1        <= phase_nxt[PHASE_WIDTH-1 -: LW];
      v1        <= voltage_signal_valid;
      l1        <= voltage_signal_valid
                   & voltage_signal_valid_last;
    end
  end

  // Odd quadrants read the table mirrored; upper half negates.
  function automatic logic [AW-1:0] qaddr(
    input logic [LW-1:0] p
  );
    logic [AW-1:0] k;
    k = AW'(p[KW-1:0]);
    return p[LW-2] ? (N_A - k) : k;
  endfunction

  // cos(x) = sin(x + quarter turn)
  assign b1       = a1 + N_L;
  assign sin_addr = qaddr(a1);
  assign cos_addr = qaddr(b1);

  vco_sin_qrom #(
    .LUT_ADDR_WIDTH (LUT_ADDR_WIDTH),
    .IQ_BIT_WIDTH   (IQ_BIT_WIDTH)
  ) u_rom (
    .clk    (clk),
    .rst_n  (rst_n),
    .addr_a (sin_addr),
    .addr_b (cos_addr),
    .mag_a  (sin_mag),
    .mag_b  (cos_mag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sin_neg2 <= 1'b0;
      cos_neg2 <= 1'b0;
      v2       <= 1'b0;
      l2       <= 1'b0;
    end else begin
      sin_neg2 <= a1[LW-1];
      cos_neg2 <= b1[LW-1];
      v2       <= v1;
      l2       <= l1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cos_out                <= '0;
      sin_out                <= '0;
      sin_cos_out_valid      <= 1'b0;
      sin_cos_out_valid_last <= 1'b0;
    end else begin
      if (v2) begin
        cos_out <= cos_neg2 ? -{1'b0, cos_mag}
                            : {1'b0, cos_mag};
        sin_out <= sin_neg2 ? -{1'b0, sin_mag}
                            : {1'b0, sin_mag};
      end
      sin_cos_out_valid      <= v2;
      sin_cos_out_valid_last <= l2;
    end
  end

endmodule

// File: tb/tb_vco_nco_qlut.sv
// Scoreboard bench: default build plus a GAIN_SHIFT=1 build
// driven with half the frequency word; both must match.
module tb_vco_nco_qlut;
  import vco_nco_qlut_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] vs;
  logic [14:0] vs2;
  logic        vld, lst, clr;
  logic [15:0] off;

  logic [7:0] c0, s0, c1, s1;
  logic       v0, l0, v1o, l1o;

  assign vs2 = vs[15:1];

  vco_nco_qlut dut0 (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .voltage_signal            (vs),
    .voltage_signal_valid      (vld),
    .voltage_signal_valid_last (lst),
    .phase_clear               (clr),
    .phase_offset              (off),
    .cos_out                   (c0),
    .sin_out                   (s0),
    .sin_cos_out_valid         (v0),
    .sin_cos_out_valid_last    (l0)
  );

  vco_nco_qlut #(
    .VCO_BIT_WIDTH (15),
    .GAIN_SHIFT    (1)
  ) dut1 (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .voltage_signal            (vs2),
    .voltage_signal_valid      (vld),
    .voltage_signal_valid_last (lst),
    .phase_clear               (clr),
    .phase_offset              (off),
    .cos_out                   (c1),
    .sin_out                   (s1),
    .sin_cos_out_valid         (v1o),
    .sin_cos_out_valid_last    (l1o)
  );

  typedef struct {
    int         cyc;
    logic [7:0] c;
    logic [7:0] s;
    logic       l;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [7:0] hold_c [2];
  logic [7:0] hold_s [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int i,
                     input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s dut%0d cyc %0d: got %0d want %0d",
               nm, i, cyc, act, req);
    end
  endtask

  task automatic mon(input int i,
                     input logic [7:0] c,
                     input logic [7:0] s,
                     input logic v, input logic l);
    exp_t e;
    int n;
    if (!rst_n) begin
      hold_c[i] = '0;
      hold_s[i] = '0;
      chk("rst_cos", i, $signed(c), 0);
      chk("rst_sin", i, $signed(s), 0);
      chk("rst_valid", i, int'(v), 0);
      chk("rst_last", i, int'(l), 0);
      return;
    end
    n = (i == 0) ? q0.size() : q1.size();
    if (v) begin
      if (n == 0) begin
        chk("stray_valid", i, 1, 0);
      end else begin
        if (i == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk("latency", i, cyc, e.cyc);
        chk("cos", i, $signed(c), $signed(e.c));
        chk("sin", i, $signed(s), $signed(e.s));
        chk("last", i, int'(l), int'(e.l));
        hold_c[i] = e.c;
        hold_s[i] = e.s;
      end
    end else begin
      chk("hold_cos", i, $signed(c), $signed(hold_c[i]));
      chk("hold_sin", i, $signed(s), $signed(hold_s[i]));
      chk("gap_last", i, int'(l), 0);
    end
  endtask

  always @(negedge clk) begin
    mon(0, c0, s0, v0, l0);
    mon(1, c1, s1, v1o, l1o);
  end

  task automatic drive(input logic [15:0] v,
                       input logic va, input logic la,
                       input logic cl, input logic [15:0] of,
                       input logic ex, input int ec,
                       input int es);
    exp_t e;
    @(posedge clk);
    #1;
    vs  = v;
    vld = va;
    lst = la;
    clr = cl;
    off = of;
    if (ex) begin
      e.cyc = cyc + 3;
      e.c   = 8'(ec);
      e.s   = 8'(es);
      e.l   = la;
      q0.push_back(e);
      q1.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(16'h0, 0, 0, 0, 16'h0, 0, 0, 0);
  endtask

  int tc [8] = '{125, 117, 106, 90, 71, 49, 25, 0};
  int ts [8] = '{25, 49, 71, 90, 106, 117, 125, 127};

  initial begin
    vs  = '0;
    vld = 1'b0;
    lst = 1'b0;
    clr = 1'b0;
    off = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    drive(16'h0000, 1, 0, 1, 16'h0, 1, 127, 0);
    drive(16'h4000, 1, 0, 0, 16'h0, 1, 0, 127);
    drive(16'h4000, 1, 0, 0, 16'h0, 1, -127, 0);
    drive(16'h4000, 1, 0, 0, 16'h0, 1, 0, -127);
    drive(16'h4000, 1, 0, 0, 16'h0, 1, 127, 0);

    drive(16'hC000, 1, 0, 0, 16'h0, 1, 0, -127);
    drive(16'h2000, 1, 0, 1, 16'h2000, 1, 0, 127);

    drive(16'h0000, 0, 0, 1, 16'h0, 0, 0, 0);
    for (int j = 0; j < 8; j++)
      drive(16'(BTLE_INC), 1, 0, 0, 16'h0, 1,
            tc[j], ts[j]);

    drive(16'h0000, 0, 0, 1, 16'h0, 0, 0, 0);
    drive(16'h4000, 1, 0, 0, 16'h0, 1, 0, 127);
    idle(2);
    drive(16'h4000, 1, 1, 0, 16'h0, 1, -127, 0);
    idle(5);

    drive(16'h4000, 1, 0, 0, 16'h0, 0, 0, 0);
    drive(16'h4000, 1, 0, 0, 16'h0, 0, 0, 0);
    drive(16'h4000, 1, 0, 0, 16'h0, 0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_cos", 0, $signed(c0), 0);
    chk("async_rst_sin", 0, $signed(s0), 0);
    chk("async_rst_valid", 0, int'(v0), 0);
    chk("async_rst_cos", 1, $signed(c1), 0);
    vld = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(5);
    drive(16'h4000, 1, 0, 0, 16'h0, 1, 0, 127);
    idle(6);

    chk("drain", 0, q0.size(), 0);
    chk("drain", 1, q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
